// File: rtl/cheri_pkg.sv
// Shared CHERI pipeline types.
// mc_state_e is the state of the multicycle sequencer in the CHERI EX stage.
package cheri_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SBND2    = 3'd1,
        LBC_DATA = 3'd2,
        REV_REQ  = 3'd3,
        REV_WAIT = 3'd4,
        LBC_WB   = 3'd5
    } mc_state_e;

endpackage

// File: rtl/cheri_mc_seq.sv
// Multicycle sequencer for CHERI EX: two-cycle bounds ops and tag-safe capability loads
// that consult the revocation bitmap before writing back the loaded capability.
module cheri_mc_seq
    import cheri_pkg::*;
#(
    parameter bit          CheriPPLBC = 1'b1,
    parameter bit          CheriSBND2 = 1'b0,
    parameter int unsigned RevTimeout = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        op_valid_i,
    input  logic        mc_i,
    input  logic        op_is_lbc_i,
    input  logic        op_is_sbnd_i,
    input  logic        kill_i,
    input  logic        lsu_done_i,
    input  logic        lsu_err_i,
    input  logic        lsu_cap_tag_i,
    input  logic [31:0] lsu_cap_base_i,
    output logic        rev_req_o,
    output logic [31:0] rev_addr_o,
    input  logic        rev_gnt_i,
    input  logic        rev_rvalid_i,
    input  logic        rev_bit_i,
    output logic        stall_o,
    output logic        stage_o,
    output logic        wb_valid_o,
    output logic        wb_clr_tag_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int unsigned    CntW    = $clog2(RevTimeout);
    localparam logic [CntW-1:0] CntLast = CntW'(RevTimeout - 2);
    localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

    mc_state_e       state_q, state_d;
    logic [31:0]     rev_addr_q, rev_addr_d;
    logic            clr_q, clr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            start_sbnd, start_lbc;

    // Qualified by rst_ni so the combinational IDLE stall is also 0 while in reset.
    assign start_sbnd = op_valid_i & mc_i & op_is_sbnd_i & CheriSBND2 & ~kill_i & rst_ni;
    assign start_lbc  = op_valid_i & mc_i & op_is_lbc_i & ~CheriPPLBC & ~kill_i & rst_ni;

    assign rev_addr_o = rev_addr_q;
    assign busy_o     = (state_q != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rev_addr_q <= '0;
            clr_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rev_addr_q <= rev_addr_d;
            clr_q      <= clr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rev_addr_d   = rev_addr_q;
        clr_d        = clr_q;
        cnt_d        = cnt_q;
        stall_o      = 1'b0;
        stage_o      = 1'b0;
        wb_valid_o   = 1'b0;
        wb_clr_tag_o = 1'b0;
        err_o        = 1'b0;
        rev_req_o    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_lbc) begin
                    stall_o = 1'b1;
                    state_d = LBC_DATA;
                end else if (start_sbnd) begin
                    stall_o = 1'b1;
                    state_d = SBND2;
                end
            end
            SBND2: begin
                stage_o = 1'b1;
                state_d = IDLE;
            end
            LBC_DATA: begin
                stall_o = 1'b1;
                if (lsu_done_i) begin
                    if (lsu_err_i) begin
                        err_o   = 1'b1;
                        state_d = IDLE;
                    end else if (!lsu_cap_tag_i) begin
                        clr_d   = 1'b0;
                        state_d = LBC_WB;
                    end else begin
                        rev_addr_d = lsu_cap_base_i;
                        state_d    = REV_REQ;
                    end
                end
            end
            REV_REQ: begin
                stall_o   = 1'b1;
                rev_req_o = 1'b1;
                if (rev_gnt_i) begin
                    cnt_d   = '0;
                    state_d = REV_WAIT;
                end
            end
            REV_WAIT: begin
                stall_o = 1'b1;
                cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
                // A missing bitmap answer is treated as revoked.
                if (rev_rvalid_i) begin
                    clr_d   = rev_bit_i;
                    state_d = LBC_WB;
                end else if (cnt_q == CntLast) begin
                    clr_d   = 1'b1;
                    state_d = LBC_WB;
                end
            end
            LBC_WB: begin
                wb_valid_o   = 1'b1;
                wb_clr_tag_o = clr_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (kill_i) begin
            state_d    = IDLE;
            wb_valid_o = 1'b0;
            err_o      = 1'b0;
        end
    end

endmodule

// File: tb/tb_cheri_mc_seq.sv
// Randomized scoreboard bench for cheri_mc_seq: the driver predicts each output event
// (stage pulse, writeback, error) with its cycle; a negedge monitor pops and compares.
module tb_cheri_mc_seq;

    localparam int REV_TO = 4;

    logic        clk_i, rst_ni;
    logic        op_valid_i, mc_i, op_is_lbc_i, op_is_sbnd_i, kill_i;
    logic        lsu_done_i, lsu_err_i, lsu_cap_tag_i;
    logic [31:0] lsu_cap_base_i;
    logic        rev_req_o;
    logic [31:0] rev_addr_o;
    logic        rev_gnt_i, rev_rvalid_i, rev_bit_i;
    logic        stall_o, stage_o, wb_valid_o, wb_clr_tag_o, err_o, busy_o;

    cheri_mc_seq #(.CheriPPLBC(1'b0), .CheriSBND2(1'b1), .RevTimeout(REV_TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .op_valid_i(op_valid_i), .mc_i(mc_i),
        .op_is_lbc_i(op_is_lbc_i), .op_is_sbnd_i(op_is_sbnd_i), .kill_i(kill_i),
        .lsu_done_i(lsu_done_i), .lsu_err_i(lsu_err_i), .lsu_cap_tag_i(lsu_cap_tag_i),
        .lsu_cap_base_i(lsu_cap_base_i), .rev_req_o(rev_req_o), .rev_addr_o(rev_addr_o),
        .rev_gnt_i(rev_gnt_i), .rev_rvalid_i(rev_rvalid_i), .rev_bit_i(rev_bit_i),
        .stall_o(stall_o), .stage_o(stage_o), .wb_valid_o(wb_valid_o),
        .wb_clr_tag_o(wb_clr_tag_o), .err_o(err_o), .busy_o(busy_o)
    );

    // kind: 0 = bounds stage pulse, 1 = writeback, 2 = load error
    typedef struct {
        int   kind;
        logic clr;
        int   cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    always @(posedge clk_i)
        assert (!(op_valid_i && mc_i && op_is_lbc_i && op_is_sbnd_i && !kill_i))
            else $error("illegal dual start driven");

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int kind, input logic clr, input int c);
        exp_t e;
        e.kind = kind;
        e.clr  = clr;
        e.cyc  = c;
        return e;
    endfunction

    // Monitor: every output event must match the oldest prediction.
    always @(negedge clk_i) begin
        if (rst_ni && (stage_o || wb_valid_o || err_o)) begin
            int   k;
            exp_t e;
            k = stage_o ? 0 : (wb_valid_o ? 1 : 2);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got kind %0d at cycle %0d, expected none", k, cyc);
            end else begin
                e = q.pop_front();
                chk("out_kind", k, e.kind);
                chk("out_cycle", cyc, e.cyc);
                if (k == 1) chk("wb_clr_tag", wb_clr_tag_o, e.clr);
            end
        end
    end

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_ins();
        op_valid_i = 0; mc_i = 0; op_is_lbc_i = 0; op_is_sbnd_i = 0; kill_i = 0;
        lsu_done_i = 0; lsu_err_i = 0; lsu_cap_tag_i = 0; lsu_cap_base_i = '0;
        rev_gnt_i = 0; rev_rvalid_i = 0; rev_bit_i = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, stall_o, 0);
        chk({tag, "_stage"}, stage_o, 0);
        chk({tag, "_wb"}, wb_valid_o, 0);
        chk({tag, "_clr"}, wb_clr_tag_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_req"}, rev_req_o, 0);
        chk({tag, "_addr"}, rev_addr_o, 0);
    endtask

    task automatic do_sbnd();
        op_valid_i = 1; mc_i = 1; op_is_sbnd_i = 1;
        q.push_back(mk(0, 1'b0, cyc + 1));
        mid();
        chk("sbnd_c0_idle", busy_o, 0);
        chk("sbnd_c0_stall", stall_o, 1);
        chk("sbnd_c0_stage", stage_o, 0);
        nxt(); clear_ins();
        mid();
        chk("sbnd_c1_stall", stall_o, 0);
        chk("sbnd_c1_busy", busy_o, 1);
        nxt();
    endtask

    task automatic do_load(input int n, input bit e, input bit tag, input logic [31:0] base,
                           input int g, input int r, input bit rb);
        int dc, gc, endc;
        op_valid_i = 1; mc_i = 1; op_is_lbc_i = 1;
        mid();
        chk("lbc_start_idle", busy_o, 0);
        chk("lbc_start_stall", stall_o, 1);
        nxt(); clear_ins();
        repeat (n) begin
            lsu_err_i = 1'($urandom); lsu_cap_tag_i = 1'($urandom);
            mid(); chk("lbc_wait_stall", stall_o, 1);
            nxt();
        end
        dc = cyc;
        lsu_done_i = 1; lsu_err_i = e; lsu_cap_tag_i = tag; lsu_cap_base_i = base;
        if (e) q.push_back(mk(2, 1'b0, dc));
        else if (!tag) q.push_back(mk(1, 1'b0, dc + 1));
        mid();
        chk("lbc_data_stall", stall_o, 1);
        chk("lbc_data_noreq", rev_req_o, 0);
        nxt(); clear_ins();
        lsu_cap_base_i = $urandom;
        if (e) begin
            mid(); chk("err_then_idle", busy_o, 0); nxt();
            return;
        end
        if (!tag) begin
            mid(); chk("untagged_noreq", rev_req_o, 0); nxt();
            return;
        end
        gc = cyc;
        for (int i = 0; i <= g; i++) begin
            rev_gnt_i = (i == g);
            mid();
            chk("rev_req", rev_req_o, 1);
            chk("rev_addr", rev_addr_o, base);
            gc = cyc;
            nxt(); rev_gnt_i = 0;
        end
        // Answer on wait cycle r arrives in time only while r <= REV_TO-2.
        if (r <= REV_TO - 2) endc = gc + 2 + r;
        else endc = gc + REV_TO;
        q.push_back(mk(1, (r <= REV_TO - 2) ? rb : 1'b1, endc));
        while (cyc <= endc) begin
            rev_rvalid_i = (cyc == gc + 1 + r);
            rev_bit_i    = rev_rvalid_i ? rb : 1'($urandom);
            mid();
            if (cyc < endc) chk("rev_wait_stall", stall_o, 1);
            else chk("wb_stall", stall_o, 0);
            nxt();
        end
        rev_rvalid_i = 0; rev_bit_i = 0;
    endtask

    task automatic do_kill();
        op_valid_i = 1; mc_i = 1; op_is_lbc_i = 1;
        nxt(); clear_ins();
        lsu_done_i = 1; lsu_cap_tag_i = 1; lsu_cap_base_i = 32'h1234_5678;
        nxt(); clear_ins();
        rev_gnt_i = 1;
        nxt(); clear_ins();
        kill_i = 1;
        mid();
        chk("kill_wait_busy", busy_o, 1);
        chk("kill_no_wb", wb_valid_o, 0);
        nxt(); clear_ins();
        rev_rvalid_i = 1; rev_bit_i = 1;
        mid();
        chk("kill_idle", busy_o, 0);
        chk("kill_late_rvalid_no_wb", wb_valid_o, 0);
        nxt(); clear_ins();
        mid(); chk("kill_stays_idle", busy_o, 0);
        nxt();
    endtask

    task automatic do_reset_mid();
        op_valid_i = 1; mc_i = 1; op_is_lbc_i = 1;
        nxt(); clear_ins();
        rst_ni = 0;
        #1;
        check_all_zero("rst_mid");
        mid(); rst_ni = 1;
        nxt();
        mid(); chk("rst_release_idle", busy_o, 0);
        nxt();
    endtask

    task automatic noise();
        bit s;
        s = 1'($urandom);
        op_valid_i = 1; mc_i = 0; op_is_lbc_i = s; op_is_sbnd_i = ~s;
        lsu_done_i = 1'($urandom); rev_rvalid_i = 1'($urandom); rev_gnt_i = 1'($urandom);
        mid(); chk("noise_no_stall", stall_o, 0);
        nxt(); clear_ins();
        mid(); chk("noise_idle", busy_o, 0);
        nxt();
    endtask

    initial begin
        clear_ins();
        rst_ni = 0;
        repeat (2) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        mid(); rst_ni = 1;
        nxt();

        do_sbnd();
        do_sbnd();
        do_load(2, 0, 0, 32'hdead_beef, 0, 0, 0);
        do_load(0, 0, 1, 32'h2000_0040, 2, 0, 1);
        do_load(1, 0, 1, 32'h2000_0080, 0, 1, 0);
        do_load(0, 0, 1, 32'h0000_1000, 1, 9, 0);
        do_load(1, 1, 1, 32'h0bad_0000, 0, 0, 0);
        do_kill();
        do_load(0, 0, 1, 32'h4000_0000, 0, 2, 0);
        do_reset_mid();

        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 3))
                0: do_sbnd();
                1: noise();
                default: do_load($urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                                 1'($urandom), $urandom, $urandom_range(0, 3),
                                 $urandom_range(0, 5), 1'($urandom));
            endcase
            repeat ($urandom_range(0, 2)) nxt();
        end

        repeat (4) nxt();
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
